// File: rtl/cmp_scan_ctrl_pkg.sv
// Shared state encodings and default sizing for the comparator scan controller.
package cmp_scan_ctrl_pkg;

  localparam int unsigned DefWidth  = 3;
  localparam int unsigned DefThresh = 3;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StScan  = 2'd1,
    StDrain = 2'd2,
    StDone  = 2'd3
  } state_e;

endpackage

// File: rtl/cmp_scan_ctrl_less_than_thresh.sv
// Combinational threshold comparator: y = (a < THRESH), unsigned.
module less_than_thresh
  import cmp_scan_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH  = DefWidth,
  parameter int unsigned THRESH = DefThresh
) (
  input  logic [WIDTH-1:0] a,
  output logic             y
);

  // Compare at 32 bits so a THRESH beyond the operand range is not truncated.
  assign y = (32'(a) < THRESH);

endmodule

// File: rtl/cmp_scan_ctrl.sv
// Sweeps a threshold comparator over [lo..hi], building a hit bitmap and hit count.
// Define CMP_REG_EN to register the comparator output (adds a one-cycle DRAIN state).
module cmp_scan_ctrl
  import cmp_scan_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH  = DefWidth,
  parameter int unsigned THRESH = DefThresh
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [WIDTH-1:0]      lo,
  input  logic [WIDTH-1:0]      hi,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic [2**WIDTH-1:0]   hit_mask,
  output logic [WIDTH:0]        hit_count
);

  localparam int unsigned Bits = 2**WIDTH;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] idx_q, idx_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [Bits-1:0]  mask_q, mask_d;
  logic [WIDTH:0]   count_q, count_d;
  logic             err_q, err_d;
  logic             y;
  logic             last;
  logic             wr_en;
  logic [WIDTH-1:0] wr_idx;
  logic             wr_val;

  less_than_thresh #(
    .WIDTH  (WIDTH),
    .THRESH (THRESH)
  ) u_cmp (
    .a (idx_q),
    .y (y)
  );

  // Termination is an equality test so hi = max never wraps idx back to 0.
  assign last = (idx_q == hi_q);

`ifdef CMP_REG_EN
  logic             y_q;
  logic             vld_q;
  logic [WIDTH-1:0] yidx_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      y_q    <= 1'b0;
      vld_q  <= 1'b0;
      yidx_q <= '0;
    end else begin
      y_q    <= y;
      vld_q  <= (state_q == StScan);
      yidx_q <= idx_q;
    end
  end

  assign wr_en  = vld_q;
  assign wr_idx = yidx_q;
  assign wr_val = y_q;
`else
  assign wr_en  = (state_q == StScan);
  assign wr_idx = idx_q;
  assign wr_val = y;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      idx_q   <= '0;
      hi_q    <= '0;
      mask_q  <= '0;
      count_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      hi_q    <= hi_d;
      mask_q  <= mask_d;
      count_q <= count_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (start) state_d = (lo > hi) ? StDone : StScan;
`ifdef CMP_REG_EN
      StScan:  if (last) state_d = StDrain;
`else
      StScan:  if (last) state_d = StDone;
`endif
      StDrain: state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    idx_d   = idx_q;
    hi_d    = hi_q;
    mask_d  = mask_q;
    count_d = count_q;
    err_d   = err_q;
    if (wr_en) begin
      mask_d[wr_idx] = wr_val;
      count_d        = count_q + (WIDTH+1)'(wr_val);
    end
    if (state_q == StScan && !last) begin
      idx_d = idx_q + WIDTH'(1);
    end
    // An accepted start clears the previous results; inverted ranges skip the scan.
    if (state_q == StIdle && start) begin
      mask_d  = '0;
      count_d = '0;
      err_d   = (lo > hi);
      hi_d    = hi;
      idx_d   = lo;
    end
  end

  always_comb begin
    busy = (state_q == StScan) || (state_q == StDrain);
    done = (state_q == StDone);
  end

  assign err       = err_q;
  assign hit_mask  = mask_q;
  assign hit_count = count_q;

endmodule

// File: tb/tb_cmp_scan_ctrl.sv
// Directed self-checking bench for cmp_scan_ctrl at WIDTH=3, THRESH=3.
module tb_cmp_scan_ctrl;

`ifdef CMP_REG_EN
  localparam int Extra = 1;
`else
  localparam int Extra = 0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [2:0] lo;
  logic [2:0] hi;
  logic       busy;
  logic       done;
  logic       err;
  logic [7:0] hit_mask;
  logic [3:0] hit_count;

  int checks = 0;
  int errors = 0;

  cmp_scan_ctrl #(
    .WIDTH  (3),
    .THRESH (3)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .lo        (lo),
    .hi        (hi),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .hit_mask  (hit_mask),
    .hit_count (hit_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Pulses start for one edge, then follows the scan to its done pulse.
  task automatic run_scan(input string tag, input logic [2:0] l, input logic [2:0] h,
                          input logic [7:0] emask, input int ecount, input logic eerr,
                          input int ebusy, input int edone, input bit poke);
    int cyc;
    int busy_cnt;
    lo = l;
    hi = h;
    start = 1'b1;
    tick();
    start = 1'b0;
    cyc = 1;
    busy_cnt = 0;
    check({tag, "_clr_mask"}, 32'(hit_mask), 32'h0);
    check({tag, "_clr_count"}, 32'(hit_count), 32'h0);
    if (poke) begin
      lo = 3'd0;
      hi = 3'd7;
      start = 1'b1;
    end
    forever begin
      if (busy) busy_cnt++;
      if (done || cyc >= 40) break;
      tick();
      start = 1'b0;
      cyc++;
    end
    check({tag, "_done_cycle"}, done ? 32'(cyc) : 32'hffff, 32'(edone));
    tick();
    start = 1'b0;
    check({tag, "_done_pulse"}, 32'(done), 32'h0);
    check({tag, "_busy_cycles"}, 32'(busy_cnt), 32'(ebusy));
    check({tag, "_mask"}, 32'(hit_mask), 32'(emask));
    check({tag, "_count"}, 32'(hit_count), 32'(ecount));
    check({tag, "_err"}, 32'(err), 32'(eerr));
  endtask

  initial begin
    int extra_done;
    int extra_busy;
    rst = 1'b1;
    start = 1'b1;
    lo = 3'd0;
    hi = 3'd7;
    tick();
    tick();
    rst = 1'b0;
    start = 1'b0;
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_done", 32'(done), 32'h0);
    check("rst_err", 32'(err), 32'h0);
    check("rst_mask", 32'(hit_mask), 32'h0);
    check("rst_count", 32'(hit_count), 32'h0);

    run_scan("full", 3'd0, 3'd7, 8'b0000_0111, 3, 1'b0, 8 + Extra, 9 + Extra, 1'b0);
    // Back-to-back: start in the cycle right after done.
    run_scan("part", 3'd2, 3'd5, 8'b0000_0100, 1, 1'b0, 4 + Extra, 5 + Extra, 1'b0);
    run_scan("inv", 3'd5, 3'd3, 8'h00, 0, 1'b1, 0, 1, 1'b0);
    run_scan("after_inv", 3'd0, 3'd0, 8'b0000_0001, 1, 1'b0, 1 + Extra, 2 + Extra, 1'b0);

    // Single top index with a start poked while busy; it must not be queued.
    run_scan("top", 3'd7, 3'd7, 8'h00, 0, 1'b0, 1 + Extra, 2 + Extra, 1'b1);
    extra_done = 0;
    extra_busy = 0;
    for (int i = 0; i < 12; i++) begin
      if (done) extra_done++;
      if (busy) extra_busy++;
      tick();
    end
    check("top_no_extra_done", 32'(extra_done), 32'h0);
    check("top_no_extra_busy", 32'(extra_busy), 32'h0);

    // Reset on the third SCAN cycle of a full sweep.
    lo = 3'd0;
    hi = 3'd7;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst_busy", 32'(busy), 32'h0);
    check("midrst_done", 32'(done), 32'h0);
    check("midrst_err", 32'(err), 32'h0);
    check("midrst_mask", 32'(hit_mask), 32'h0);
    check("midrst_count", 32'(hit_count), 32'h0);
    extra_done = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (done) extra_done++;
    end
    check("midrst_no_done", 32'(extra_done), 32'h0);
    run_scan("post_rst", 3'd0, 3'd2, 8'b0000_0111, 3, 1'b0, 3 + Extra, 4 + Extra, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
